// File: rtl/csr_access_arb_if.sv
// Signal bundle around csr_access_arb: two requester ports, the CSR register port and status.
// "slave" is the arbiter's view; "master" is the view of the surrounding logic.
interface csr_access_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_wr_en;
    logic              r0_rd_en;
    logic [DATA_W-1:0] r0_wr_data;
    logic              r0_ready;
    logic [DATA_W-1:0] r0_rd_data;
    logic              r0_rd_dvalid;

    logic [ADDR_W-1:0] r1_addr;
    logic              r1_wr_en;
    logic              r1_rd_en;
    logic [DATA_W-1:0] r1_wr_data;
    logic              r1_ready;
    logic [DATA_W-1:0] r1_rd_data;
    logic              r1_rd_dvalid;

    logic [ADDR_W-1:0] wr_rd_addr;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_datain;
    logic              rd_dvalid;

    logic              busy;
    logic              grant_owner;
    logic              timeout_err;

    modport slave (
        input  r0_addr, r0_wr_en, r0_rd_en, r0_wr_data,
        output r0_ready, r0_rd_data, r0_rd_dvalid,
        input  r1_addr, r1_wr_en, r1_rd_en, r1_wr_data,
        output r1_ready, r1_rd_data, r1_rd_dvalid,
        output wr_rd_addr, wr_en, rd_en, wr_data,
        input  rd_datain, rd_dvalid,
        output busy, grant_owner, timeout_err
    );

    modport master (
        output r0_addr, r0_wr_en, r0_rd_en, r0_wr_data,
        input  r0_ready, r0_rd_data, r0_rd_dvalid,
        output r1_addr, r1_wr_en, r1_rd_en, r1_wr_data,
        input  r1_ready, r1_rd_data, r1_rd_dvalid,
        input  wr_rd_addr, wr_en, rd_en, wr_data,
        output rd_datain, rd_dvalid,
        input  busy, grant_owner, timeout_err
    );
endinterface

// File: rtl/csr_access_arb.sv
// Round-robin arbiter sharing the CSR controller register port between the JTAG bridge (r0)
// and the test sequencer (r1); routes read responses to their owner and times out lost reads.
module csr_access_arb #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 32,
    parameter int                RD_TIMEOUT   = 64,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    csr_access_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_WR = 2'd1,
        ISSUE_RD = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    localparam int              CNT_W    = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  to_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] r0_hold_q;
    logic [DATA_W-1:0] r1_hold_q;

    logic              req0;
    logic              req1;
    logic              take;
    logic              winner;
    logic              win_wr;
    logic              rsp_vld;
    logic              rsp_to;
    logic [DATA_W-1:0] rsp_data;
    logic              done;

    // The counter parks on the compare value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_LAST) ? v : v + CNT_W'(1);
    endfunction

    assign req0 = bus.r0_wr_en | bus.r0_rd_en;
    assign req1 = bus.r1_wr_en | bus.r1_rd_en;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        winner    = 1'b0;
        win_wr    = 1'b0;
        rsp_vld   = 1'b0;
        rsp_to    = 1'b0;
        rsp_data  = bus.rd_datain;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take      = 1'b1;
                    winner    = (req0 && req1) ? ~last_grant_q : req1;
                    // A combined write+read request is executed as a write only.
                    win_wr    = winner ? bus.r1_wr_en : bus.r0_wr_en;
                    state_nxt = win_wr ? ISSUE_WR : ISSUE_RD;
                end
            end
            ISSUE_WR: state_nxt = IDLE;
            ISSUE_RD: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (bus.rd_dvalid) begin
                    rsp_vld   = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == CNT_LAST) begin
                    rsp_vld   = 1'b1;
                    rsp_to    = 1'b1;
                    rsp_data  = TIMEOUT_DATA;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant capture, round-robin history and read timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            to_cnt       <= '0;
        end else begin
            if (take) begin
                addr_q       <= winner ? bus.r1_addr    : bus.r0_addr;
                wdata_q      <= winner ? bus.r1_wr_data : bus.r0_wr_data;
                owner_q      <= winner;
                last_grant_q <= winner;
            end
            if (state == ISSUE_RD) begin
                to_cnt <= '0;
            end else if (state == RD_WAIT) begin
                to_cnt <= sat_inc(to_cnt);
            end
        end
    end

    // Per-requester read data holds its last delivered value between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0_hold_q <= '0;
            r1_hold_q <= '0;
        end else if (rsp_vld) begin
            if (owner_q) begin
                r1_hold_q <= rsp_data;
            end else begin
                r0_hold_q <= rsp_data;
            end
        end
    end

    assign done = (state == ISSUE_WR) | rsp_vld;

    assign bus.wr_en       = (state == ISSUE_WR);
    assign bus.rd_en       = (state == ISSUE_RD);
    assign bus.wr_rd_addr  = addr_q;
    assign bus.wr_data     = wdata_q;
    assign bus.busy        = (state != IDLE);
    assign bus.grant_owner = owner_q;
    assign bus.timeout_err = rsp_to;

    assign bus.r0_ready     = done & ~owner_q;
    assign bus.r1_ready     = done &  owner_q;
    assign bus.r0_rd_dvalid = rsp_vld & ~owner_q;
    assign bus.r1_rd_dvalid = rsp_vld &  owner_q;
    assign bus.r0_rd_data   = (rsp_vld & ~owner_q) ? rsp_data : r0_hold_q;
    assign bus.r1_rd_data   = (rsp_vld &  owner_q) ? rsp_data : r1_hold_q;
endmodule
